// File: rtl/alu_sequencer.sv
// Sequences one operation through an external ALU: IDLE -> LOAD -> EXEC -> WB.
// Optional feature: define ALU_SEQ_DIVZERO_TRAP_EN to trap DIV by zero as an error.
module alu_sequencer #(
    parameter int MULDIV_LAT = 4,
    parameter int SIMPLE_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_z,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        zero_flag,
    output logic [31:0] result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

    localparam logic [3:0] OP_MUL     = 4'd5;
    localparam logic [3:0] OP_DIV     = 4'd6;
    localparam logic [3:0] SIMPLE_CNT = 4'(SIMPLE_LAT);
    localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  opReg_q, opReg_d;
    logic [31:0] aReg_q, aReg_d, bReg_q, bReg_d;
    logic [31:0] aluA_q, aluA_d, aluB_q, aluB_d;
    logic [3:0]  aluOp_q, aluOp_d;
    logic        skip_q, skip_d;
    logic        done_q, done_d, err_q, err_d, zero_q, zero_d;
    logic [31:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic        isMulDiv, divZeroTrap;
    logic        unusedZHi;

    // Only the low word of Z carries a simple-op result.
    assign unusedZHi = ^alu_z[63:32];

    assign isMulDiv = (opReg_q == OP_MUL) || (opReg_q == OP_DIV);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    assign divZeroTrap = (opReg_q == OP_DIV) && (bReg_q == 32'd0);
`else
    assign divZeroTrap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opReg_q  <= '0;
            aReg_q   <= '0;
            bReg_q   <= '0;
            aluA_q   <= '0;
            aluB_q   <= '0;
            aluOp_q  <= '0;
            skip_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opReg_q  <= opReg_d;
            aReg_q   <= aReg_d;
            bReg_q   <= bReg_d;
            aluA_q   <= aluA_d;
            aluB_q   <= aluB_d;
            aluOp_q  <= aluOp_d;
            skip_q   <= skip_d;
            done_q   <= done_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opReg_d  = opReg_q;
        aReg_d   = aReg_q;
        bReg_d   = bReg_q;
        aluA_d   = aluA_q;
        aluB_d   = aluB_q;
        aluOp_d  = aluOp_q;
        skip_d   = skip_q;
        done_d   = 1'b0;
        err_d    = err_q;
        zero_d   = zero_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opReg_d = op_in;
                    aReg_d  = a_in;
                    bReg_d  = b_in;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                aluA_d  = aReg_q;
                aluB_d  = bReg_q;
                aluOp_d = opReg_q;
                cnt_d   = isMulDiv ? MULDIV_CNT : SIMPLE_CNT;
                skip_d  = (opReg_q > OP_DIV) || divZeroTrap;
                state_d = skip_d ? WB : EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = WB;
                end
            end
            WB: begin
                // Results and done are registered here, so they appear as we reach IDLE.
                done_d  = 1'b1;
                state_d = IDLE;
                if (skip_q) begin
                    err_d = 1'b1;
                end else if (isMulDiv) begin
                    hi_d     = alu_hi;
                    lo_d     = alu_lo;
                    result_d = alu_lo;
                    zero_d   = ({alu_hi, alu_lo} == 64'd0);
                end else begin
                    result_d = alu_z[31:0];
                    zero_d   = (alu_z[31:0] == 32'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign zero_flag = zero_q;
    assign result    = result_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign alu_a     = aluA_q;
    assign alu_b     = aluB_q;
    assign alu_op    = aluOp_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer: directed vectors with hand-computed results,
// plus hand-written sequences for start-while-busy and mid-operation reset.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  op_in;
    logic [31:0] a_in, b_in;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_z;
    logic [31:0] alu_hi, alu_lo;
    logic        busy, done, err, zero_flag;
    logic [31:0] result, hi_out, lo_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic [31:0] expRes;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expZero;
        logic        expErr;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op_in(op_in),
        .a_in(a_in), .b_in(b_in), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .busy(busy), .done(done), .err(err), .zero_flag(zero_flag),
        .result(result), .hi_out(hi_out), .lo_out(lo_out)
    );

    function automatic vec_t mkVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [63:0] z, input logic [31:0] hi, input logic [31:0] lo,
                                   input int lat, input logic [31:0] expRes, input logic [31:0] expHi,
                                   input logic [31:0] expLo, input logic expZero, input logic expErr);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.z = z; v.hi = hi; v.lo = lo; v.lat = lat;
        v.expRes = expRes; v.expHi = expHi; v.expLo = expLo; v.expZero = expZero; v.expErr = expErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Start one operation, measure edges from acceptance to done, then check all outputs.
    task automatic applyStimulus(input vec_t v, input string tag);
        int cycles;
        @(negedge clk);
        op_in = v.op; a_in = v.a; b_in = v.b;
        alu_z = v.z; alu_hi = v.hi; alu_lo = v.lo;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1 cycles++;
        end
        checkOutput({tag, " latency"}, 64'(cycles), 64'(v.lat));
        checkOutput({tag, " result"}, 64'(result), 64'(v.expRes));
        checkOutput({tag, " hi_out"}, 64'(hi_out), 64'(v.expHi));
        checkOutput({tag, " lo_out"}, 64'(lo_out), 64'(v.expLo));
        checkOutput({tag, " zero_flag"}, 64'(zero_flag), 64'(v.expZero));
        checkOutput({tag, " err"}, 64'(err), 64'(v.expErr));
        checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
        checkOutput({tag, " alu_a"}, 64'(alu_a), 64'(v.a));
        checkOutput({tag, " alu_b"}, 64'(alu_b), 64'(v.b));
        checkOutput({tag, " alu_op"}, 64'(alu_op), 64'(v.op));
        @(posedge clk);
        #1 checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int doneCount;
        logic sawDone;

        vecs[0]  = mkVec(4'd3, 32'd5, 32'd7, 64'd12, 32'd0, 32'd0, 3, 32'd12, 32'd0, 32'd0, 1'b0, 1'b0);
        vecs[1]  = mkVec(4'd5, 32'h10000, 32'h10000, 64'h1_0000_0000, 32'd1, 32'd0, 6, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
        vecs[2]  = mkVec(4'd4, 32'd9, 32'd9, 64'd0, 32'd0, 32'd0, 3, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0);
        vecs[3]  = mkVec(4'd0, 32'hFFFF0000, 32'h00FF00FF, 64'h00FF0000, 32'd0, 32'd0, 3, 32'h00FF0000, 32'd1, 32'd0, 1'b0, 1'b0);
        vecs[4]  = mkVec(4'hF, 32'd1, 32'd2, 64'h123, 32'h55, 32'h66, 2, 32'h00FF0000, 32'd1, 32'd0, 1'b0, 1'b1);
        vecs[5]  = mkVec(4'd1, 32'd0, 32'd0, 64'hFFFF_FFFF_0000_0000, 32'd0, 32'd0, 3, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        vecs[6]  = mkVec(4'd6, 32'd10, 32'd0, 64'd0, 32'hAAAA, 32'h5555, 2, 32'd0, 32'd1, 32'd0, 1'b1, 1'b1);
`else
        vecs[6]  = mkVec(4'd6, 32'd10, 32'd0, 64'd0, 32'hAAAA, 32'h5555, 6, 32'h5555, 32'hAAAA, 32'h5555, 1'b0, 1'b0);
`endif
        vecs[7]  = mkVec(4'd6, 32'd100, 32'd7, 64'd0, 32'd2, 32'd14, 6, 32'd14, 32'd2, 32'd14, 1'b0, 1'b0);
        vecs[8]  = mkVec(4'd5, 32'd0, 32'd3, 64'd7, 32'd0, 32'd0, 6, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        vecs[9]  = mkVec(4'd2, 32'd0, 32'd0, 64'hFFFFFFFF, 32'd0, 32'd0, 3, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0);
        vecs[10] = mkVec(4'd7, 32'd3, 32'd4, 64'd0, 32'h9, 32'h9, 2, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1);
        vecs[11] = mkVec(4'd3, 32'd1, 32'd2, 64'd3, 32'd0, 32'd0, 3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);

        reset = 1'b1; start = 1'b0; op_in = '0; a_in = '0; b_in = '0;
        alu_z = '0; alu_hi = '0; alu_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset outputs", {32'(result), 32'(hi_out | lo_out)}, 64'd0);
        checkOutput("reset alu drive", {alu_a, alu_b | 32'(alu_op)}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // SUB with start re-asserted every busy cycle, including WB: only one done.
        op_in = 4'd4; a_in = 32'd9; b_in = 32'd9; alu_z = 64'd0; alu_hi = '0; alu_lo = '0;
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = (c == 0) || busy;
            @(posedge clk);
            #1 if (done) doneCount++;
        end
        start = 1'b0;
        checkOutput("start while busy done count", 64'(doneCount), 64'd1);
        checkOutput("start while busy result", 64'(result), 64'd0);
        checkOutput("start while busy zero_flag", 64'(zero_flag), 64'd1);

        // Reset during EXEC of a MUL aborts it without a done pulse.
        @(negedge clk);
        op_in = 4'd5; a_in = 32'd6; b_in = 32'd7; alu_hi = 32'h1; alu_lo = 32'h2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput("mid-exec busy before reset", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort outputs", {32'(result), 32'(hi_out | lo_out)}, 64'd0);
        checkOutput("abort flags", {62'd0, zero_flag, err}, 64'd0);
        checkOutput("abort alu drive", {alu_a, alu_b | 32'(alu_op)}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (done) sawDone = 1'b1;
        end
        checkOutput("abort no late done", 64'(sawDone), 64'd0);
        applyStimulus(mkVec(4'd3, 32'd20, 32'd22, 64'd42, 32'd0, 32'd0, 3, 32'd42, 32'd0, 32'd0, 1'b0, 1'b0),
                      "post-reset add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
